// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: widths, ALU function codes and
// the multi-cycle latency class of each function.
package alu_pkg;

    localparam int ALU_XLEN = 32;
    localparam int ALU_RA   = 5;

    localparam logic [5:0] ALU_NOP    = 6'b000000;
    localparam logic [5:0] ALU_ADD    = 6'b100000;
    localparam logic [5:0] ALU_SUB    = 6'b100010;
    localparam logic [5:0] ALU_AND    = 6'b100100;
    localparam logic [5:0] ALU_OR     = 6'b100101;
    localparam logic [5:0] ALU_XOR    = 6'b100110;
    localparam logic [5:0] ALU_SLT    = 6'b101010;
    localparam logic [5:0] ALU_LUI    = 6'b001111;
    localparam logic [5:0] ALU_FMADD  = 6'b010000;
    localparam logic [5:0] ALU_FMSUB  = 6'b010001;
    localparam logic [5:0] ALU_FMUL   = 6'b010010;
    localparam logic [5:0] ALU_FDIV   = 6'b010011;
    localparam logic [5:0] ALU_FNMADD = 6'b010100;
    localparam logic [5:0] ALU_FCVT   = 6'b010111;
    localparam logic [5:0] ALU_FADD   = 6'b011001;
    localparam logic [5:0] ALU_FSUB   = 6'b011010;
    localparam logic [5:0] ALU_FMIN   = 6'b011110;
    localparam logic [5:0] ALU_FMAX   = 6'b011111;

    // Number of extra cycles the ALU needs before its result is valid.
    function automatic logic [1:0] lat_class(input logic [5:0] ctl);
        logic [1:0] cls;
        cls = 2'd0;
        case (ctl)
            ALU_FADD, ALU_FSUB, ALU_FCVT, ALU_FMIN, ALU_FMAX: cls = 2'd1;
            ALU_FMADD, ALU_FMSUB, ALU_FMUL, ALU_FNMADD:        cls = 2'd2;
            ALU_FDIV:                                          cls = 2'd3;
            default:                                           cls = 2'd0;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_issue_fwd_sel.sv
// Operand bypass select for one source register: x0, then the EX-stage
// result, then the WB-stage result, then the register file.
module fwd_sel #(
    parameter int XLEN = 32,
    parameter int RA   = 5
) (
    input  logic [RA-1:0]   rs,
    input  logic            ex_valid,
    input  logic            ex_we,
    input  logic [RA-1:0]   ex_rd,
    input  logic            wb_valid,
    input  logic            wb_we,
    input  logic [RA-1:0]   wb_rd,
    input  logic [XLEN-1:0] alu_fwd,
    input  logic [XLEN-1:0] wb_res,
    input  logic [XLEN-1:0] rf_data,
    output logic [XLEN-1:0] val
);

    always_comb begin
        val = rf_data;
        if (rs == '0) begin
            val = '0;
        end else if (ex_valid && ex_we && (ex_rd == rs)) begin
            val = alu_fwd;
        end else if (wb_valid && wb_we && (wb_rd == rs)) begin
            val = wb_res;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issue/EX register stage ahead of the ALU: operand bypassing, multi-cycle
// FP stall generation and register-file write tracking.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN,
    parameter int RA   = ALU_RA
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [5:0]      id_aluctl,
    input  logic [RA-1:0]   id_rs1,
    input  logic [RA-1:0]   id_rs2,
    input  logic [RA-1:0]   id_rd,
    input  logic            id_we,
    input  logic            id_use_imm,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_fwd,
    input  logic [XLEN-1:0] wb_res,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [5:0]      aluctl,
    output logic            stall,
    output logic            id_ready,
    output logic            rf_we,
    output logic [RA-1:0]   rf_wa
);

    logic            ex_valid;
    logic            ex_we;
    logic [RA-1:0]   ex_rd;
    logic [1:0]      ex_cnt;
    logic            wb_valid;
    logic            wb_we;
    logic [RA-1:0]   wb_rd;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
    logic            accept;

    fwd_sel #(.XLEN(XLEN), .RA(RA)) u_fwd_rs1 (
        .rs       (id_rs1),
        .ex_valid (ex_valid),
        .ex_we    (ex_we),
        .ex_rd    (ex_rd),
        .wb_valid (wb_valid),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .alu_fwd  (alu_fwd),
        .wb_res   (wb_res),
        .rf_data  (id_rs1_data),
        .val      (fwd1)
    );

    fwd_sel #(.XLEN(XLEN), .RA(RA)) u_fwd_rs2 (
        .rs       (id_rs2),
        .ex_valid (ex_valid),
        .ex_we    (ex_we),
        .ex_rd    (ex_rd),
        .wb_valid (wb_valid),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .alu_fwd  (alu_fwd),
        .wb_res   (wb_res),
        .rf_data  (id_rs2_data),
        .val      (fwd2)
    );

    assign stall    = ex_valid && (ex_cnt != 2'd0);
    assign id_ready = ~stall;
    assign accept   = id_valid && !flush;
    assign rf_we    = wb_valid && wb_we;
    assign rf_wa    = wb_rd;

    // While stalled only the latency counter moves; flush is ignored until release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op1      <= '0;
            op2      <= '0;
            aluctl   <= ALU_NOP;
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            ex_rd    <= '0;
            ex_cnt   <= 2'd0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
        end else if (stall) begin
            ex_cnt <= ex_cnt - 2'd1;
        end else begin
            wb_valid <= ex_valid;
            wb_we    <= ex_we;
            wb_rd    <= ex_rd;
            if (accept) begin
                op1      <= fwd1;
                op2      <= id_use_imm ? id_imm : fwd2;
                aluctl   <= id_aluctl;
                ex_valid <= 1'b1;
                ex_we    <= id_we && (id_rd != '0);
                ex_rd    <= id_rd;
                ex_cnt   <= lat_class(id_aluctl);
            end else begin
                op1      <= '0;
                op2      <= '0;
                aluctl   <= ALU_NOP;
                ex_valid <= 1'b0;
                ex_we    <= 1'b0;
                ex_rd    <= '0;
                ex_cnt   <= 2'd0;
            end
        end
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue/EX-register stage directly upstream of the ALU. Latches decoded instructions into the ALU operand registers (`op1`, `op2`, `aluctl`) and resolves RAW hazards by forwarding from the ALU's combinational result (`alu_fwd`) and registered result (`wb_res`). Tracks in-flight multi-cycle FP latency to generate the global pipeline stall. Tracks the destination of the writeback-stage result and drives the register-file write port.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `RA`, 5, register address width

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low (asserted at 0)
- `id_valid` in 1: decoded instruction present
- `id_aluctl` in 6: ALU function code
- `id_rs1`, `id_rs2`, `id_rd` in RA: source and destination registers
- `id_we` in 1: instruction writes `id_rd`
- `id_use_imm` in 1: `op2` takes `id_imm` instead of rs2
- `id_imm` in XLEN: immediate
- `id_rs1_data`, `id_rs2_data` in XLEN: register-file read data
- `flush` in 1: turn the incoming instruction into a bubble
- `alu_fwd` in XLEN: ALU combinational result of the EX-stage op
- `wb_res` in XLEN: ALU registered result
- `op1`, `op2` out XLEN: registered ALU operands
- `aluctl` out 6: registered ALU function
- `stall` out 1: global stall, to the front end and to the ALU `stall` input
- `id_ready` out 1: equals `~stall`
- `rf_we` out 1, `rf_wa` out RA: register-file write, aligned with `wb_res`

## Operation
- **Latency class** of `id_aluctl`:
  - 1: 011001, 011010, 010111, 011110, 011111
  - 2: 010000, 010001, 010010, 010100
  - 3: 010011
  - 0: all other codes
- **EX register** (`op1`, `op2`, `aluctl`, `ex_valid`, `ex_we`, `ex_rd`, `ex_cnt[1:0]`):
  - Loads when `stall` = 0.
  - Holds when `stall` = 1.
- **Load with `id_valid` & ~`flush`:**
  - `ex_cnt` takes the latency class.
  - `ex_we` takes `id_we` & (`id_rd` != 0).
- **Load with ~`id_valid` | `flush`:** bubble. `ex_valid` = 0, `ex_we` = 0, `aluctl` = 000000, `op1` = `op2` = 0, `ex_cnt` = 0.
- **`ex_cnt`:** decrements each cycle while non-zero.
- **`stall`:** `ex_valid` & (`ex_cnt` != 0).
- **WB register** (`wb_valid`, `wb_we`, `wb_rd`): loads the EX fields when `stall` = 0, holds otherwise.
- **Register-file write:**
  - `rf_we` = `wb_valid` & `wb_we`; `rf_wa` = `wb_rd`.
  - The write repeats while held; this is idempotent.
- **Forwarding per source `rs`**, priority high to low:
  1. `rs` == 0: value 0.
  2. `ex_valid` & `ex_we` & `ex_rd` == `rs`: `alu_fwd`.
  3. `wb_valid` & `wb_we` & `wb_rd` == `rs`: `wb_res`.
  4. Otherwise: register-file data.
- `op2` = `id_imm` when `id_use_imm`; rs2 forwarding is then irrelevant.
- `flush` is sampled only when `stall` = 0. The requester holds `flush` through a stall.

## Timing
- Instruction accepted at edge t; `op1`/`op2`/`aluctl` are valid from cycle t.
- Class L: `stall` is high for cycles t..t+L−1.
  - `alu_fwd` is valid at t+L.
  - `wb_res` and `rf_we` appear at t+L+1.
- A dependent instruction held in ID during the stall captures `alu_fwd` on the release edge. No extra bubble is inserted.
- Back-to-back class-0 ops sustain one issue per cycle.
- Reset (any time, asynchronous):
  - `op1` = `op2` = 0, `aluctl` = 0.
  - `ex_valid` = `wb_valid` = 0, `ex_cnt` = 0.
  - `stall` = 0, `rf_we` = 0, `rf_wa` = 0.
  - An in-flight multi-cycle op is discarded.
- Simultaneous `flush` and `id_valid` with `stall` = 0: the bubble wins.
- `rs1` == `rs2`: both operands take the same forwarded value.

## Structure
- Package `alu_pkg`:
  - `aluctl` code localparams (ADD, SUB, FADD, …, LUI).
  - Function `lat_class(logic [5:0]) -> logic [1:0]`.
  - XLEN/RA constants.
- Sub-module `fwd_sel`: combinational 4-way operand select, instantiated for rs1 and rs2.
- The rest (EX/WB registers, counter) stays in `alu_issue`.

## Test plan
- **Reset mid-operation:**
  - Stimulus: assert `rst` = 0 with `ex_cnt` = 2 (during an fdiv).
  - Response: `stall`, `ex_valid`, `rf_we` are 0 immediately.
  - Response: after release, the first `id_valid` add issues with `stall` = 0.
- **Back-to-back integer ops:**
  - Stimulus: `add x1,x0+5` (imm), then `add x2,x1+x1`.
  - Response: second op gets `op1` = `op2` = `alu_fwd` (5).
  - Response: `rf_we` for x1 then x2 on consecutive cycles, `stall` never high.
- **fmul (010010) into x3, dependent `fadd x4,x3,x3` in ID:**
  - Response: `stall` high exactly 2 cycles.
  - Response: fadd latches `alu_fwd` at release.
  - Response: `rf_we`/`rf_wa` = 3 one cycle later.
- **fdiv (010011):**
  - Response: `stall` high 3 cycles, `id_ready` low 3 cycles.
  - Response: `aluctl` holds 010011 throughout.
- **`flush` with `id_valid` = 1 while stall = 0:**
  - Response: EX loads a bubble (`aluctl` 000000, `op1` = `op2` = 0), no `rf_we` for that slot.
  - Stimulus: `flush` during a stall.
  - Response: no effect until release.
- **Destination x0:**
  - Stimulus: `add x0,…` then a reader of x0.
  - Response: `rf_we` = 0, reader sees 0 and not `alu_fwd`.
  - Stimulus: WB-only match, rd = 7 two cycles back.
  - Response: selects `wb_res`.
